// File: rtl/afe_flag_detect.sv
// rtl/afe_flag_detect.sv - per-channel threshold/debounce flag detector
//
// Purpose: two-stage pipeline that classifies synchronized ADC samples
// against a high/low threshold pair and runs a per-channel debounce FSM
// (IN_RANGE / ABOVE / BELOW), emitting one-cycle flag events.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   cfg_en_i              detector enable; low flushes all state
//   cfg_ch_mask_i         per-channel monitor enable
//   cfg_thr_hi_i/lo_i     unsigned thresholds (lo <= hi)
//   cfg_debounce_i        consecutive samples required (0 acts as 1)
//   adc_rx_valid_i/data_i synchronized sample stream (chid embedded)
//   flags_valid_o         one-cycle flag event
//   flags_o               bit0 high crossing, bit1 low crossing
//   flags_chid_o          channel that raised the flag
module afe_flag_detect #(
    parameter int ADC_DATA_WIDTH = 32,
    parameter int ADC_NUM_CHS    = 8,
    parameter int CH_ID_LSB      = 28,
    parameter int CH_ID_WIDTH    = 4,
    parameter int SAMPLE_WIDTH   = 16,
    parameter int CNT_WIDTH      = 4,
    parameter int FLAG_WIDTH     = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cfg_en_i,
    input  logic [ADC_NUM_CHS-1:0]    cfg_ch_mask_i,
    input  logic [SAMPLE_WIDTH-1:0]   cfg_thr_hi_i,
    input  logic [SAMPLE_WIDTH-1:0]   cfg_thr_lo_i,
    input  logic [CNT_WIDTH-1:0]      cfg_debounce_i,
    input  logic                      adc_rx_valid_i,
    input  logic [ADC_DATA_WIDTH-1:0] adc_rx_data_i,
    output logic                      flags_valid_o,
    output logic [FLAG_WIDTH-1:0]     flags_o,
    output logic [CH_ID_WIDTH-1:0]    flags_chid_o
);

    localparam int IDX_W = (ADC_NUM_CHS > 1) ? $clog2(ADC_NUM_CHS) : 1;

    localparam logic [1:0] ST_IN    = 2'd0;
    localparam logic [1:0] ST_ABOVE = 2'd1;
    localparam logic [1:0] ST_BELOW = 2'd2;

    logic [CH_ID_WIDTH-1:0]  chid;
    logic [SAMPLE_WIDTH-1:0] sample;
    logic                    accept;
    logic                    unused_data;

    assign chid        = adc_rx_data_i[CH_ID_LSB +: CH_ID_WIDTH];
    assign sample      = adc_rx_data_i[SAMPLE_WIDTH-1:0];
    assign unused_data = ^adc_rx_data_i;

    // Stage 1 registers
    logic                   s1_valid_q, s1_valid_d;
    logic [CH_ID_WIDTH-1:0] s1_chid_q,  s1_chid_d;
    logic                   s1_hi_q,    s1_hi_d;
    logic                   s1_lo_q,    s1_lo_d;
    logic [CNT_WIDTH-1:0]   s1_deb_q,   s1_deb_d;

    // Per-channel FSM state
    logic [1:0]           state_q [ADC_NUM_CHS];
    logic [1:0]           state_d [ADC_NUM_CHS];
    logic [CNT_WIDTH-1:0] cnt_q   [ADC_NUM_CHS];
    logic [CNT_WIDTH-1:0] cnt_d   [ADC_NUM_CHS];
    logic                 dir_q   [ADC_NUM_CHS];
    logic                 dir_d   [ADC_NUM_CHS];

    // Outputs
    logic                   flags_valid_q, flags_valid_d;
    logic [FLAG_WIDTH-1:0]  flags_q,       flags_d;
    logic [CH_ID_WIDTH-1:0] flags_chid_q,  flags_chid_d;

    // Stage 1: acceptance filter and threshold classification.
    // Out-of-range chids never match a mask bit, so they are dropped here.
    always_comb begin
        accept = 1'b0;
        for (int i = 0; i < ADC_NUM_CHS; i++) begin
            if (chid == CH_ID_WIDTH'(i) && cfg_ch_mask_i[i]) begin
                accept = 1'b1;
            end
        end
        s1_valid_d = accept & cfg_en_i & adc_rx_valid_i;
        s1_chid_d  = chid;
        s1_hi_d    = sample > cfg_thr_hi_i;
        s1_lo_d    = sample < cfg_thr_lo_i;
        s1_deb_d   = (cfg_debounce_i == '0) ? CNT_WIDTH'(1) : cfg_debounce_i;
    end

    // Stage 2: channel FSM update
    logic [IDX_W-1:0]     idx;
    logic [1:0]           cur;
    logic [1:0]           tgt;
    logic                 up;
    logic [CNT_WIDTH-1:0] cnt_cur;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic [CNT_WIDTH-1:0] cnt_nxt;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        dir_d         = dir_q;
        flags_valid_d = 1'b0;
        flags_d       = '0;
        flags_chid_d  = '0;

        idx     = s1_chid_q[IDX_W-1:0];
        cur     = state_q[idx];
        cnt_cur = cnt_q[idx];
        tgt     = s1_hi_q ? ST_ABOVE : (s1_lo_q ? ST_BELOW : ST_IN);
        // Each state has two exit candidates; 'up' marks the higher one
        // (ordering lo < in < hi) so a change of candidate restarts the count.
        up      = (tgt == ST_ABOVE) || (cur == ST_ABOVE && tgt == ST_IN);
        cnt_inc = (cnt_cur == '1) ? cnt_cur : cnt_cur + 1'b1;
        cnt_nxt = (cnt_cur != '0 && dir_q[idx] != up) ? CNT_WIDTH'(1) : cnt_inc;

        if (s1_valid_q) begin
            if (tgt == cur) begin
                cnt_d[idx] = '0;
            end else if (cnt_nxt >= s1_deb_q) begin
                // >= so a debounce lowered mid-count still terminates
                state_d[idx] = tgt;
                cnt_d[idx]   = '0;
                if (tgt != ST_IN) begin
                    flags_valid_d = 1'b1;
                    flags_d       = (tgt == ST_ABOVE) ? FLAG_WIDTH'(1) : FLAG_WIDTH'(2);
                    flags_chid_d  = s1_chid_q;
                end
            end else begin
                cnt_d[idx] = cnt_nxt;
                dir_d[idx] = up;
            end
        end
    end

    // Disable acts exactly like reset, including the in-flight stage-1 sample.
    always_ff @(posedge clk_i) begin
        if (rst_i || !cfg_en_i) begin
            s1_valid_q    <= 1'b0;
            s1_chid_q     <= '0;
            s1_hi_q       <= 1'b0;
            s1_lo_q       <= 1'b0;
            s1_deb_q      <= CNT_WIDTH'(1);
            flags_valid_q <= 1'b0;
            flags_q       <= '0;
            flags_chid_q  <= '0;
            for (int i = 0; i < ADC_NUM_CHS; i++) begin
                state_q[i] <= ST_IN;
                cnt_q[i]   <= '0;
                dir_q[i]   <= 1'b0;
            end
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_chid_q     <= s1_chid_d;
            s1_hi_q       <= s1_hi_d;
            s1_lo_q       <= s1_lo_d;
            s1_deb_q      <= s1_deb_d;
            flags_valid_q <= flags_valid_d;
            flags_q       <= flags_d;
            flags_chid_q  <= flags_chid_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dir_q         <= dir_d;
        end
    end

    assign flags_valid_o = flags_valid_q;
    assign flags_o       = flags_q;
    assign flags_chid_o  = flags_chid_q;

endmodule

// File: tb/tb_afe_flag_detect.sv
// tb/tb_afe_flag_detect.sv - self-checking bench for afe_flag_detect
module tb_afe_flag_detect;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cfg_en_i = 1'b1;
    logic [7:0]  cfg_ch_mask_i = 8'hFF;
    logic [15:0] cfg_thr_hi_i = 16'd1000;
    logic [15:0] cfg_thr_lo_i = 16'd100;
    logic [3:0]  cfg_debounce_i = 4'd3;
    logic        adc_rx_valid_i = 1'b0;
    logic [31:0] adc_rx_data_i = '0;
    logic        flags_valid_o;
    logic [1:0]  flags_o;
    logic [3:0]  flags_chid_o;

    afe_flag_detect dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cfg_en_i       (cfg_en_i),
        .cfg_ch_mask_i  (cfg_ch_mask_i),
        .cfg_thr_hi_i   (cfg_thr_hi_i),
        .cfg_thr_lo_i   (cfg_thr_lo_i),
        .cfg_debounce_i (cfg_debounce_i),
        .adc_rx_valid_i (adc_rx_valid_i),
        .adc_rx_data_i  (adc_rx_data_i),
        .flags_valid_o  (flags_valid_o),
        .flags_o        (flags_o),
        .flags_chid_o   (flags_chid_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_fail = 0;
    int nstep = 0;

    // Reference model: channel rest class (0 below, 1 in range, 2 above),
    // consecutive count toward a different class, and that candidate class.
    int m_st [8];
    int m_cnt [8];
    int m_last [8];

    logic       pend_v;
    logic [1:0] pend_f;
    logic [3:0] pend_c;
    logic       exp_v, obs_v;
    logic [1:0] exp_f, obs_f;
    logic [3:0] exp_c, obs_c;
    int ev_step [$];
    int ev_f [$];
    int ev_c [$];

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_st[i] = 1; m_cnt[i] = 0; m_last[i] = 1;
        end
    endtask

    task automatic model_sample(input int ch, input int s, output logic v,
                                output logic [1:0] f);
        int cls, d;
        v = 1'b0; f = 2'b00;
        d = (cfg_debounce_i == 0) ? 1 : int'(cfg_debounce_i);
        cls = (s > int'(cfg_thr_hi_i)) ? 2 : ((s < int'(cfg_thr_lo_i)) ? 0 : 1);
        if (cls == m_st[ch]) begin
            m_cnt[ch] = 0;
        end else begin
            if (m_cnt[ch] > 0 && cls != m_last[ch]) m_cnt[ch] = 1;
            else m_cnt[ch] = (m_cnt[ch] + 1 > 15) ? 15 : m_cnt[ch] + 1;
            m_last[ch] = cls;
            if (m_cnt[ch] >= d) begin
                m_st[ch] = cls;
                m_cnt[ch] = 0;
                if (cls != 1) begin
                    v = 1'b1;
                    f = (cls == 2) ? 2'b01 : 2'b10;
                end
            end
        end
    endtask

    // Drive one cycle of stimulus, advance the model, sample DUT outputs.
    task automatic step(input logic v, input logic [3:0] ch, input logic [15:0] s);
        logic nv;
        logic [1:0] nf;
        logic flush;
        nv = 1'b0; nf = 2'b00;
        adc_rx_valid_i = v;
        adc_rx_data_i = {ch, 12'($urandom), s};
        flush = rst_i || !cfg_en_i;
        if (flush) model_reset();
        else if (v && ch < 8 && cfg_ch_mask_i[ch[2:0]])
            model_sample(int'(ch[2:0]), int'(s), nv, nf);
        @(posedge clk_i);
        #1;
        if (flush) begin
            exp_v = 1'b0; exp_f = 2'b00; exp_c = 4'd0;
            pend_v = 1'b0; pend_f = 2'b00; pend_c = 4'd0;
        end else begin
            exp_v = pend_v; exp_f = pend_f; exp_c = pend_c;
            pend_v = nv; pend_f = nf; pend_c = nv ? ch : 4'd0;
        end
        obs_v = flags_valid_o; obs_f = flags_o; obs_c = flags_chid_o;
        if (obs_v) begin
            ev_step.push_back(nstep); ev_f.push_back(int'(obs_f)); ev_c.push_back(int'(obs_c));
        end
        nstep++;
        adc_rx_valid_i = 1'b0;
    endtask

    task automatic start_test(output int base);
        cfg_en_i = 1'b1; cfg_ch_mask_i = 8'hFF;
        cfg_thr_hi_i = 16'd1000; cfg_thr_lo_i = 16'd100; cfg_debounce_i = 4'd3;
        rst_i = 1'b1;
        step(1'b0, 4'd0, 16'd0);
        rst_i = 1'b0;
        ev_step.delete(); ev_f.delete(); ev_c.delete();
        base = nstep;
    endtask

    task automatic test_reset();
        int base;
        rst_i = 1'b1;
        step(1'b1, 4'd2, 16'd5000);
        step(1'b1, 4'd2, 16'd5000);
        n_cmp++;
        if ({flags_valid_o, flags_o, flags_chid_o} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b f=%b c=%0d, need all 0", flags_valid_o, flags_o, flags_chid_o);
        end
        start_test(base);
    endtask

    task automatic test_basic();
        int base;
        start_test(base);
        for (int i = 0; i < 6; i++) begin
            step(i < 4, 4'd2, 16'd1001);
            n_cmp++;
            if ({obs_v, obs_f, obs_c} !== {exp_v, exp_f, exp_c}) begin
                n_fail++;
                $display("FAIL basic_step%0d: got %b/%b/%0d need %b/%b/%0d", i, obs_v, obs_f, obs_c, exp_v, exp_f, exp_c);
            end
        end
        n_cmp++;
        if (ev_step.size() != 1 || ev_step[0] != base + 3 || ev_f[0] != 1 || ev_c[0] != 2) begin
            n_fail++;
            $display("FAIL basic_event: got %0d events, need one 01/ch2 at step %0d", ev_step.size(), base + 3);
        end
    endtask

    task automatic test_debounce_break();
        int base;
        int smp [6] = '{1001, 1001, 500, 1001, 1001, 1001};
        start_test(base);
        for (int i = 0; i < 8; i++) begin
            step(i < 6, 4'd5, (i < 6) ? 16'(smp[i]) : 16'd0);
            n_cmp++;
            if ({obs_v, obs_f, obs_c} !== {exp_v, exp_f, exp_c}) begin
                n_fail++;
                $display("FAIL break_step%0d: got %b/%b/%0d need %b/%b/%0d", i, obs_v, obs_f, obs_c, exp_v, exp_f, exp_c);
            end
        end
        n_cmp++;
        if (ev_step.size() != 1 || ev_step[0] != base + 6 || ev_f[0] != 1 || ev_c[0] != 5) begin
            n_fail++;
            $display("FAIL break_event: got %0d events, need one 01/ch5 at step %0d", ev_step.size(), base + 6);
        end
    endtask

    task automatic test_hysteresis();
        int base;
        int smp [14] = '{1000, 1000, 1000, 1000, 1000, 50, 50, 50, 500, 500, 500, 2000, 2000, 2000};
        start_test(base);
        for (int i = 0; i < 16; i++) begin
            step(i < 14, 4'd0, (i < 14) ? 16'(smp[i]) : 16'd0);
            n_cmp++;
            if ({obs_v, obs_f, obs_c} !== {exp_v, exp_f, exp_c}) begin
                n_fail++;
                $display("FAIL hyst_step%0d: got %b/%b/%0d need %b/%b/%0d", i, obs_v, obs_f, obs_c, exp_v, exp_f, exp_c);
            end
        end
        n_cmp++;
        if (ev_step.size() != 2 || ev_step[0] != base + 8 || ev_f[0] != 2 || ev_c[0] != 0
            || ev_step[1] != base + 14 || ev_f[1] != 1) begin
            n_fail++;
            $display("FAIL hyst_events: got %0d events, need 10@%0d and 01@%0d", ev_step.size(), base + 8, base + 14);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        start_test(base);
        for (int i = 0; i < 8; i++) begin
            if (i < 6) step(1'b1, (i % 2 == 0) ? 4'd1 : 4'd3, (i % 2 == 0) ? 16'd2000 : 16'd10);
            else step(1'b0, 4'd0, 16'd0);
            n_cmp++;
            if ({obs_v, obs_f, obs_c} !== {exp_v, exp_f, exp_c}) begin
                n_fail++;
                $display("FAIL b2b_step%0d: got %b/%b/%0d need %b/%b/%0d", i, obs_v, obs_f, obs_c, exp_v, exp_f, exp_c);
            end
        end
        n_cmp++;
        if (ev_step.size() != 2 || ev_step[0] != base + 5 || ev_f[0] != 1 || ev_c[0] != 1
            || ev_step[1] != base + 6 || ev_f[1] != 2 || ev_c[1] != 3) begin
            n_fail++;
            $display("FAIL b2b_events: got %0d events, need 01/ch1@%0d then 10/ch3@%0d", ev_step.size(), base + 5, base + 6);
        end
    endtask

    task automatic test_filtering();
        int base;
        start_test(base);
        for (int i = 0; i < 13; i++) begin
            cfg_ch_mask_i = (i inside {[3:5], 8, 9}) ? 8'hEF : 8'hFF;
            if (i < 3) step(1'b1, 4'd12, 16'd2000);
            else if (i < 11) step(1'b1, 4'd4, 16'd2000);
            else step(1'b0, 4'd0, 16'd0);
            n_cmp++;
            if ({obs_v, obs_f, obs_c} !== {exp_v, exp_f, exp_c}) begin
                n_fail++;
                $display("FAIL filter_step%0d: got %b/%b/%0d need %b/%b/%0d", i, obs_v, obs_f, obs_c, exp_v, exp_f, exp_c);
            end
        end
        n_cmp++;
        if (ev_step.size() != 1 || ev_step[0] != base + 11 || ev_f[0] != 1 || ev_c[0] != 4) begin
            n_fail++;
            $display("FAIL filter_event: got %0d events, need one 01/ch4 at step %0d", ev_step.size(), base + 11);
        end
    endtask

    task automatic test_abort();
        int base;
        for (int mode = 0; mode < 2; mode++) begin
            start_test(base);
            for (int i = 0; i < 11; i++) begin
                if (i == 3) begin
                    if (mode == 0) rst_i = 1'b1; else cfg_en_i = 1'b0;
                end else begin
                    rst_i = 1'b0; cfg_en_i = 1'b1;
                end
                step(i inside {0, 1, 2, 4, 5, 8}, 4'd2, 16'd1001);
                n_cmp++;
                if ({obs_v, obs_f, obs_c} !== {exp_v, exp_f, exp_c}) begin
                    n_fail++;
                    $display("FAIL abort%0d_step%0d: got %b/%b/%0d need %b/%b/%0d", mode, i, obs_v, obs_f, obs_c, exp_v, exp_f, exp_c);
                end
            end
            n_cmp++;
            if (ev_step.size() != 1 || ev_step[0] != base + 9 || ev_f[0] != 1 || ev_c[0] != 2) begin
                n_fail++;
                $display("FAIL abort%0d_event: got %0d events, need one 01/ch2 at step %0d", mode, ev_step.size(), base + 9);
            end
        end
        start_test(base);
        cfg_debounce_i = 4'd0;
        step(1'b1, 4'd6, 16'd50);
        step(1'b0, 4'd0, 16'd0);
        n_cmp++;
        if (ev_step.size() != 1 || ev_step[0] != base + 1 || ev_f[0] != 2 || ev_c[0] != 6) begin
            n_fail++;
            $display("FAIL debounce0_event: got %0d events, need one 10/ch6 at step %0d", ev_step.size(), base + 1);
        end
    endtask

    task automatic test_random();
        int base;
        logic [15:0] s;
        logic [15:0] a, b;
        start_test(base);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                a = 16'($urandom_range(50, 400));
                b = 16'($urandom_range(50, 400));
                cfg_thr_lo_i = (a < b) ? a : b;
                cfg_thr_hi_i = (a < b) ? b : a;
                cfg_debounce_i = 4'($urandom_range(0, 4));
            end
            if ($urandom_range(0, 99) < 2) cfg_ch_mask_i = 8'($urandom);
            rst_i = ($urandom_range(0, 199) == 0);
            cfg_en_i = ($urandom_range(0, 99) != 0);
            case ($urandom_range(0, 3))
                0: s = cfg_thr_hi_i;
                1: s = cfg_thr_lo_i;
                default: s = 16'($urandom_range(0, 460));
            endcase
            step($urandom_range(0, 9) < 8, 4'($urandom_range(0, 9)), s);
            n_cmp++;
            if ({obs_v, obs_f, obs_c} !== {exp_v, exp_f, exp_c}) begin
                n_fail++;
                $display("FAIL random_step%0d: got %b/%b/%0d need %b/%b/%0d", i, obs_v, obs_f, obs_c, exp_v, exp_f, exp_c);
            end
        end
        rst_i = 1'b0; cfg_en_i = 1'b1;
    endtask

    initial begin
        model_reset();
        pend_v = 1'b0; pend_f = 2'b00; pend_c = 4'd0;
        test_reset();
        test_basic();
        test_debounce_break();
        test_hysteresis();
        test_back_to_back();
        test_filtering();
        test_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
